// File: rtl/network_acc_requant_29s_16s.sv
// rtl/network_acc_requant_29s_16s.sv - grouped product accumulator with rounded, saturating requantization to 16 bits
module network_acc_requant_29s_16s #(
  parameter int KERNEL_LEN = 9,
  parameter int SHIFT      = 12,
  parameter int RELU       = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [28:0] prod,
  input  logic signed [15:0] bias,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] dout
);

  localparam int CW = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(KERNEL_LEN - 1);
  localparam logic signed [39:0] ROUND = 40'sd1 <<< (SHIFT - 1);
  localparam logic signed [39:0] SAT_MAX = 40'sd32767;
  localparam logic signed [39:0] SAT_MIN = -40'sd32768;

  logic signed [39:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic signed [15:0] dout_q, dout_d;

  logic               accept;
  logic               first_prod;
  logic               last_prod;
  logic signed [39:0] bias_ext;
  logic signed [39:0] prod_ext;
  logic signed [39:0] acc_base;
  logic signed [39:0] acc_sum;
  logic signed [39:0] rounded;
  logic signed [39:0] shifted;
  logic signed [15:0] sat_val;
  logic signed [15:0] result;

  // A pending result that is not being drained blocks new products, so the
  // last product of the next group can never overwrite an unconsumed result.
  assign in_ready   = ce & ~(out_valid_q & ~out_ready);
  assign accept     = in_valid & in_ready;
  assign first_prod = (cnt_q == '0);
  assign last_prod  = (cnt_q == CNT_LAST);

  assign bias_ext = {{24{bias[15]}}, bias};
  assign prod_ext = {{11{prod[28]}}, prod};

  // Accumulate, then round half up, shift, saturate and optionally clamp at zero.
  always_comb begin
    acc_base = first_prod ? (bias_ext <<< SHIFT) : acc_q;
    acc_sum  = acc_base + prod_ext;
    rounded  = acc_sum + ROUND;
    shifted  = rounded >>> SHIFT;
    if (shifted > SAT_MAX) begin
      sat_val = 16'sh7fff;
    end else if (shifted < SAT_MIN) begin
      sat_val = -16'sh8000;
    end else begin
      sat_val = shifted[15:0];
    end
    if ((RELU != 0) && sat_val[15]) begin
      result = '0;
    end else begin
      result = sat_val;
    end
  end

  // Next-state: ce gates everything; a last accept reloads dout even while it is being drained.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    if (ce) begin
      if (accept) begin
        acc_d = acc_sum;
        cnt_d = last_prod ? '0 : cnt_q + 1'b1;
      end
      if (accept && last_prod) begin
        dout_d      = result;
        out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers; reset wins over ce and drops any partial group.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_network_acc_requant_29s_16s.sv
// tb/tb_network_acc_requant_29s_16s.sv - directed-vector bench for network_acc_requant_29s_16s
module tb_network_acc_requant_29s_16s;

  logic clk = 1'b0;
  logic reset;
  logic ce;
  logic in_valid;
  logic out_ready;
  logic signed [28:0] prod;
  logic signed [15:0] bias;

  logic rdy_a, ov_a, rdy_b, ov_b, rdy_c, ov_c;
  logic signed [15:0] dout_a, dout_b, dout_c;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  network_acc_requant_29s_16s #(.KERNEL_LEN(3), .SHIFT(12), .RELU(0)) dut_a (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy_a),
    .prod(prod), .bias(bias), .out_valid(ov_a), .out_ready(out_ready), .dout(dout_a)
  );

  network_acc_requant_29s_16s #(.KERNEL_LEN(1), .SHIFT(12), .RELU(0)) dut_b (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy_b),
    .prod(prod), .bias(bias), .out_valid(ov_b), .out_ready(out_ready), .dout(dout_b)
  );

  network_acc_requant_29s_16s #(.KERNEL_LEN(1), .SHIFT(12), .RELU(1)) dut_c (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy_c),
    .prod(prod), .bias(bias), .out_valid(ov_c), .out_ready(out_ready), .dout(dout_c)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input int b);
    prod     = 29'(p);
    bias     = 16'(b);
    in_valid = 1'b1;
    tick();
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    ce        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    prod      = '0;
    bias      = '0;
    tick();
    tick();
    chk("rst_ov", ov_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_rdy", rdy_a, 1);
    ce = 1'b0;
    #1;
    chk("rst_rdy_ce0", rdy_a, 0);
    ce    = 1'b1;
    reset = 1'b0;

    // basic sum with rounding
    send(4096, 0);
    send(8192, 0);
    chk("basic_ov_early", ov_a, 0);
    send(-2048, 0);
    chk("basic_ov", ov_a, 1);
    chk("basic_dout", dout_a, 3);
    in_valid = 1'b0;
    tick();
    chk("basic_drain", ov_a, 0);

    // saturation both ways, back to back
    send(134217728, 0);
    send(134217728, 0);
    send(134217728, 0);
    chk("sat_pos", dout_a, 32767);
    send(-134217728, 0);
    chk("sat_ov_clear", ov_a, 0);
    send(-134217728, 0);
    send(-134217728, 0);
    chk("sat_neg", dout_a, -32768);
    chk("sat_neg_ov", ov_a, 1);

    // single-product groups: rounding and relu
    pulse_reset();
    send(-2048, 0);
    chk("k1_half", dout_b, 0);
    chk("k1_ov", ov_b, 1);
    send(-2049, 0);
    chk("k1_neg", dout_b, -1);
    chk("k1_relu", dout_c, 0);
    send(2048, 0);
    chk("k1_pos", dout_b, 1);
    chk("k1_pos_relu", dout_c, 1);
    send(0, -1);
    chk("k1_bias", dout_b, -1);
    chk("k1_bias_relu", dout_c, 0);
    in_valid = 1'b0;

    // backpressure then back-to-back groups
    pulse_reset();
    out_ready = 1'b0;
    send(4096, 0);
    send(4096, 0);
    send(4096, 0);
    chk("bp_ov", ov_a, 1);
    chk("bp_dout", dout_a, 3);
    prod     = 29'(999);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_rdy", rdy_a, 0);
      chk("bp_hold", dout_a, 3);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_xfer", ov_a, 0);
    chk("bp_rdy_after", rdy_a, 1);
    send(4096, 0);
    send(4096, 0);
    send(4096, 0);
    chk("b2b_g1", dout_a, 3);
    chk("b2b_rdy", rdy_a, 1);
    send(8192, 0);
    send(8192, 0);
    send(8192, 0);
    chk("b2b_g2", dout_a, 6);
    chk("b2b_g2_ov", ov_a, 1);
    send(4096, 1);
    send(4096, 100);
    send(4096, 100);
    chk("b2b_g3_bias", dout_a, 4);
    chk("b2b_g3_ov", ov_a, 1);

    // reset mid-group
    send(4096, 0);
    send(4096, 0);
    pulse_reset();
    chk("mid_rst_ov", ov_a, 0);
    chk("mid_rst_dout", dout_a, 0);
    send(4096, 1);
    send(4096, 0);
    send(4096, 0);
    chk("mid_rst_dout2", dout_a, 4);
    chk("mid_rst_ov2", ov_a, 1);
    in_valid = 1'b0;

    // clock enable low holds everything
    ce = 1'b0;
    tick();
    tick();
    chk("ce_hold_ov", ov_a, 1);
    ce = 1'b1;
    send(4096, 0);
    chk("ce_pre_ov", ov_a, 0);
    ce   = 1'b0;
    prod = 29'(1000000);
    for (int i = 0; i < 5; i++) begin
      in_valid  = i[0];
      out_ready = ~i[0];
      tick();
      chk("ce_rdy", rdy_a, 0);
    end
    ce        = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    #1;
    chk("ce_ov_held", ov_a, 0);
    chk("ce_dout_held", dout_a, 4);
    send(8192, 0);
    send(-2048, 0);
    chk("ce_sum", dout_a, 3);
    chk("ce_ov", ov_a, 1);
    in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
